// File: rtl/dmem_copier.sv
// Word-block copy engine: owns the data-memory port while busy and moves
// len words from src to dst in ascending order, one read and one write per word.
module dmem_copier #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    output logic             mem_we,
    input  logic [31:0]      mem_rd
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [31:0]      cur_src_q, cur_src_d;
    logic [31:0]      cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0] rem_q,     rem_d;
    logic [31:0]      data_q,    data_d;
    logic             err_q,     err_d;

    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        data_d    = data_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_src_d = src;
                    cur_dst_d = dst;
                    rem_d     = len;
                    err_d     = 1'b0;
                    if ((src[1:0] != 2'b00) || (dst[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                data_d  = mem_rd;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // Addresses wrap modulo 2^32 by construction of the 32-bit add.
                cur_src_d = cur_src_q + 32'd4;
                cur_dst_d = cur_dst_q + 32'd4;
                rem_d     = rem_q - 1'b1;
                state_d   = (rem_q == LEN_W'(1)) ? S_DONE : S_READ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;
    // Reset gates the strobe so a word in flight is not committed to memory.
    assign mem_we = (state_q == S_WRITE) && !reset;
    assign mem_wd = (state_q == S_WRITE) ? data_q : 32'd0;
    assign mem_a  = (state_q == S_READ)  ? cur_src_q :
                    (state_q == S_WRITE) ? cur_dst_q : 32'd0;

endmodule

// File: tb/tb_dmem_copier.sv
// Directed bench for dmem_copier with a 64-word behavioural data memory.
module tb_dmem_copier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src, dst;
    logic [6:0]  len;
    logic        busy, done, err, mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [64];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    int checks = 0;
    int failures = 0;

    int          r_done, r_busy, n_wr, n_rd;
    logic        r_err, timeout, idle_ok;
    logic [31:0] rd_a [4];
    logic [31:0] wr_a [4];

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        logic [6:0]  n;
        logic        exp_err;
        int          exp_done;
        int          exp_wr;
        logic [31:0] a0, v0, a1, v1;
    } vec_t;
    vec_t vt [6];

    dmem_copier #(.LEN_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_a = 6'(idx); pre_d = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Pulses start, then watches the transfer cycle by cycle until done.
    // perturb>0 re-pulses start with different operands in that cycle.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                            input logic [6:0] n, input int perturb);
        @(negedge clk);
        src = s; dst = d; len = n; start = 1'b1;
        r_done = 0; r_busy = 0; n_wr = 0; n_rd = 0; r_err = 1'b0; timeout = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == perturb);
            if (k == perturb) begin src = 32'h40; dst = 32'hB0; len = 7'd5; end
            if (busy) r_busy++;
            if (mem_we) begin
                if (n_wr < 4) wr_a[n_wr] = mem_a;
                n_wr++;
            end else if (busy && !done) begin
                if (n_rd < 4) rd_a[n_rd] = mem_a;
                n_rd++;
            end
            if (done) begin
                r_done = k; r_err = err; timeout = 1'b0;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        idle_ok = !busy && !done && !mem_we && (mem_a == 32'd0) && (mem_wd == 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        vt[0] = '{32'h00, 32'h40, 7'd4, 1'b0, 9, 4, 32'h40, 32'd1, 32'h4C, 32'd4};
        vt[1] = '{32'h00, 32'h10, 7'd0, 1'b0, 1, 0, 32'h10, 32'h104, 32'h10, 32'h104};
        vt[2] = '{32'h02, 32'h20, 7'd3, 1'b1, 1, 0, 32'h20, 32'h108, 32'h24, 32'h109};
        vt[3] = '{32'h04, 32'h20, 7'd2, 1'b0, 5, 2, 32'h20, 32'd2, 32'h24, 32'd3};
        vt[4] = '{32'h40, 32'h60, 7'd3, 1'b0, 7, 3, 32'h60, 32'd1, 32'h68, 32'd3};
        vt[5] = '{32'h00, 32'h41, 7'd2, 1'b1, 1, 0, 32'h40, 32'd1, 32'h44, 32'd2};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_mem_we", 32'(mem_we), 0);

        for (int i = 0; i < 64; i++) poke(i, 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));

        for (int i = 0; i < 6; i++) begin
            run_xfer(vt[i].s, vt[i].d, vt[i].n, 0);
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 0);
            chk($sformatf("v%0d_done_cyc", i), 32'(r_done), 32'(vt[i].exp_done));
            chk($sformatf("v%0d_busy_cyc", i), 32'(r_busy), 32'(vt[i].exp_done));
            chk($sformatf("v%0d_writes", i), 32'(n_wr), 32'(vt[i].exp_wr));
            chk($sformatf("v%0d_err", i), 32'(r_err), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_idle", i), 32'(idle_ok), 1);
            chk($sformatf("v%0d_mem0", i), mem[vt[i].a0[7:2]], vt[i].v0);
            chk($sformatf("v%0d_mem1", i), mem[vt[i].a1[7:2]], vt[i].v1);
        end

        // Error flag holds through idle, then clears on the next accepted start.
        run_xfer(32'h1, 32'h0, 7'd1, 0);
        repeat (3) @(negedge clk);
        chk("err_held", 32'(err), 1);
        run_xfer(32'h0, 32'h0, 7'd0, 0);
        chk("err_cleared", 32'(r_err), 0);

        // Overlapping forward copy propagates the first word.
        poke(0, 32'hA); poke(1, 32'hB);
        run_xfer(32'h0, 32'h4, 7'd2, 0);
        chk("ovl_mem4", mem[1], 32'hA);
        chk("ovl_mem8", mem[2], 32'hA);

        // Source address wraps past the top of the address space.
        poke(63, 32'hDEAD); poke(0, 32'hBEEF);
        run_xfer(32'hFFFF_FFFC, 32'h80, 7'd2, 0);
        chk("wrap_rd0", rd_a[0], 32'hFFFF_FFFC);
        chk("wrap_rd1", rd_a[1], 32'h0);
        chk("wrap_wr0", wr_a[0], 32'h80);
        chk("wrap_wr1", wr_a[1], 32'h84);
        chk("wrap_mem80", mem[32], 32'hDEAD);
        chk("wrap_mem84", mem[33], 32'hBEEF);
        chk("wrap_err", 32'(r_err), 0);

        // Reset during the second write cycle drops that word.
        poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
        poke(36, 32'h0); poke(37, 32'h0);
        @(negedge clk);
        src = 32'h0; dst = 32'h90; len = 7'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_we_before", 32'(mem_we), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_we", 32'(mem_we), 0);
        chk("rstmid_mem_a", mem_a, 0);
        chk("rstmid_mem_wd", mem_wd, 0);
        chk("rstmid_w0", mem[36], 32'h11);
        chk("rstmid_w1", mem[37], 32'h0);

        // Reset and start together: request is dropped.
        @(negedge clk);
        src = 32'h0; dst = 32'hC0; len = 7'd1; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", 32'(busy), 0);
        @(negedge clk);
        chk("rst_start_busy2", 32'(busy), 0);

        // Start and new operands while busy are ignored.
        run_xfer(32'h0, 32'hA0, 7'd2, 2);
        chk("ign_done_cyc", 32'(r_done), 5);
        chk("ign_writes", 32'(n_wr), 2);
        chk("ign_memA0", mem[40], 32'h11);
        chk("ign_memA4", mem[41], 32'h22);
        chk("ign_memB0", mem[44], 32'h12C);
        chk("ign_idle", 32'(idle_ok), 1);
        @(negedge clk);
        chk("ign_no_restart", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_copier.md
# dmem_copier

Word-block copy engine that acts as the initiator on the data-memory port: it drives address, write-data and write-enable into a single-port, word-addressed data memory with combinational read and clocked write, and reads back its read-data. Given a source byte address, destination byte address and word count, it copies words upward in address order, one word per two cycles. It sits beside the core and takes ownership of the data-memory port only while busy, for preloading, clearing and moving buffers during bring-up and test.

## Interface
- LEN_W, 7, width of the word-count input (up to 127 words per transfer)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- src  in  32  source byte address; must be word aligned
- dst  in  32  destination byte address; must be word aligned
- len  in  LEN_W  number of 32-bit words to copy
- busy  out  1  high in READ, WRITE and DONE states
- done  out  1  one-cycle pulse at completion (also on error or len==0)
- err  out  1  set on misaligned request; held until next accepted start or reset
- mem_a  out  32  byte address to data memory (memory uses bits [31:2])
- mem_wd  out  32  write data to data memory
- mem_we  out  1  write enable to data memory
- mem_rd  in  32  combinational read data from data memory

## Operation
- States: IDLE, READ, WRITE, DONE. Reset: state=IDLE, busy=0, done=0, err=0, mem_a=0, mem_wd=0, mem_we=0, internal counters 0.
- IDLE, start=1: latch src, dst, len into registers, clear err.
  - src[1:0]!=0 or dst[1:0]!=0: err<=1, go DONE (no memory access).
  - len==0: go DONE (no memory access).
  - otherwise go READ.
- READ: mem_a=cur_src, mem_we=0; capture mem_rd into data register at clock edge; go WRITE.
- WRITE: mem_a=cur_dst, mem_wd=data register, mem_we=1; at edge cur_src+=4, cur_dst+=4, remaining-=1; remaining becomes 0 -> DONE, else READ.
- DONE: done=1 for exactly one cycle, go IDLE.
- Address arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- Overlap: strictly ascending copy; when dst>src and regions overlap, already-written words are re-read (forward propagation); this is the defined behaviour.
- start while busy: ignored, not queued. src/dst/len changes while busy: no effect.
- mem_we is 1 only in WRITE; mem_a=0 and mem_wd=0 in IDLE and DONE.

## Timing
- All outputs decoded from registered state; no combinational path from start/src/dst/len or mem_rd to any output.
- start sampled high at edge E0: READ in cycle after E0, first write in next cycle.
- Transfer of N words (N>0, aligned): busy high for 2N+1 cycles; done in cycle 2N+1 after E0; IDLE next; new start accepted that IDLE cycle.
- len==0 or misaligned: DONE in cycle after E0, busy high 1 cycle.
- Memory writes at the rising edge ending each WRITE cycle; read data valid combinationally during READ.
- Reset mid-transfer: next cycle IDLE with mem_we=0; the word in flight is not written; memory contents already written are retained.
- reset and start in same cycle: reset wins, request dropped.

## Test plan
- Preload mem[0x00..0x0C]=1,2,3,4; start src=0x0, dst=0x40, len=4 -> four writes to 0x40..0x4C with 1..4, done in cycle 9 after start, busy 9 cycles, err=0.
- start src=0x0, dst=0x10, len=0 -> done one cycle after start, mem_we never asserted, err=0.
- start src=0x2, dst=0x20, len=3 -> err=1, done next cycle, no writes; then aligned start -> err clears.
- Overlap: mem[0]=0xA, mem[4]=0xB; start src=0x0, dst=0x4, len=2 -> mem[4]=0xA, mem[8]=0xA.
- Wrap: src=0xFFFFFFFC, dst=0x80, len=2 -> reads at 0xFFFFFFFC then 0x00000000, writes at 0x80, 0x84.
- Assert reset during 2nd WRITE of len=4 copy -> only first word written, IDLE and all outputs 0 next cycle; start re-pulsed during busy in separate run is ignored.
